// File: rtl/car_motion_unit_if.sv
// car_motion_unit_if
//   Groups the controller-facing signals of the elevator car motion unit.
//   master : controller side (drives motor/direction, observes car status)
//   slave  : car_motion_unit side
//   motor       1 = movement requested, 0 = stop
//   direction   1 = up, 0 = down (meaningful while motor=1)
//   floor_cur   current / last-passed floor index
//   moving      car is between floors
//   arrive      one-cycle pulse when floor_cur changes
//   door_open   doors are open
//   limit_fault sticky end-of-shaft request fault
interface car_motion_unit_if;
    logic       motor;
    logic       direction;
    logic [4:0] floor_cur;
    logic       moving;
    logic       arrive;
    logic       door_open;
    logic       limit_fault;

    modport master (
        output motor, direction,
        input  floor_cur, moving, arrive, door_open, limit_fault
    );

    modport slave (
        input  motor, direction,
        output floor_cur, moving, arrive, door_open, limit_fault
    );
endinterface

// File: rtl/car_motion_unit.sv
// car_motion_unit
//   Moves an elevator car one floor per TRAVEL_CYC cycles, opens the doors
//   for DOOR_CYC cycles after each stop, and flags requests that would drive
//   the car past either end of the shaft.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : car_motion_unit_if.slave (motor/direction in, car status out)
module car_motion_unit #(
    parameter int NUM_FLOORS  = 5,
    parameter int TRAVEL_CYC  = 8,
    parameter int DOOR_CYC    = 4,
    parameter int START_FLOOR = 0
) (
    input  logic               clk,
    input  logic               rst,
    car_motion_unit_if.slave   bus
);

    localparam int CW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [4:0]    TOP_FLOOR = 5'(NUM_FLOORS - 1);
    localparam logic [4:0]    INIT_FLOOR = 5'(START_FLOOR);
    localparam logic [CW-1:0] SEG_LAST = CW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYC - 1);

    typedef enum logic [1:0] {PARKED, TRAVEL, DOORS} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_door_cnt, w_door_cnt_nxt;
    logic [4:0]    r_floor, w_floor_nxt;
    logic          r_dir, w_dir_nxt;
    logic          r_stop, w_stop_nxt;
    logic          r_arrive, w_arrive_nxt;
    logic          r_fault, w_fault_nxt;
    logic [4:0]    w_floor_step;

    // A move is illegal when it would leave the served floor range.
    function automatic logic illegal_move(input logic [4:0] floor, input logic up);
        return up ? (floor == TOP_FLOOR) : (floor == 5'd0);
    endfunction

    // Floor reached at the end of the current segment, using the latched direction.
    assign w_floor_step = r_dir ? (r_floor + 5'd1) : (r_floor - 5'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_door_cnt_nxt = r_door_cnt;
        w_floor_nxt    = r_floor;
        w_dir_nxt      = r_dir;
        w_stop_nxt     = r_stop;
        w_arrive_nxt   = 1'b0;
        w_fault_nxt    = r_fault;
        case (r_state)
            PARKED: begin
                if (bus.motor) begin
                    if (illegal_move(r_floor, bus.direction)) begin
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = TRAVEL;
                        w_cnt_nxt   = '0;
                        w_dir_nxt   = bus.direction;
                        w_stop_nxt  = 1'b0;
                    end
                end
            end
            TRAVEL: begin
                // A stop request is remembered but the segment is always finished.
                if (!bus.motor) w_stop_nxt = 1'b1;
                if (r_cnt == SEG_LAST) begin
                    w_cnt_nxt    = '0;
                    w_floor_nxt  = w_floor_step;
                    w_arrive_nxt = 1'b1;
                    if (r_stop || !bus.motor) begin
                        w_state_nxt    = DOORS;
                        w_door_cnt_nxt = '0;
                    end else if (illegal_move(w_floor_step, bus.direction)) begin
                        // Asked to keep going past an end floor: stop here and flag it.
                        w_fault_nxt    = 1'b1;
                        w_state_nxt    = DOORS;
                        w_door_cnt_nxt = '0;
                    end else begin
                        // Continue or reverse without passing through PARKED.
                        w_dir_nxt = bus.direction;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DOORS: begin
                if (r_door_cnt == DOOR_LAST) begin
                    w_state_nxt = PARKED;
                    w_stop_nxt  = 1'b0;
                end else begin
                    w_door_cnt_nxt = r_door_cnt + 1'b1;
                end
            end
            default: w_state_nxt = PARKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= PARKED;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_door_cnt <= '0;
            r_floor    <= INIT_FLOOR;
            r_dir      <= 1'b0;
            r_stop     <= 1'b0;
            r_arrive   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_door_cnt <= w_door_cnt_nxt;
            r_floor    <= w_floor_nxt;
            r_dir      <= w_dir_nxt;
            r_stop     <= w_stop_nxt;
            r_arrive   <= w_arrive_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign bus.floor_cur   = r_floor;
    assign bus.moving      = (r_state == TRAVEL);
    assign bus.door_open   = (r_state == DOORS);
    assign bus.arrive      = r_arrive;
    assign bus.limit_fault = r_fault;

endmodule

// File: tb/tb_car_motion_unit.sv
// tb_car_motion_unit
//   Directed test of car_motion_unit with default parameters. Inputs change
//   1 time unit after a rising edge; outputs are checked at the same point.
module tb_car_motion_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    car_motion_unit_if bus();

    car_motion_unit #(
        .NUM_FLOORS (5),
        .TRAVEL_CYC (8),
        .DOOR_CYC   (4),
        .START_FLOOR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input int fl, input int mv,
                          input int ar, input int dr, input int lf);
        chk({tag, ".floor"}, int'(bus.floor_cur), fl);
        chk({tag, ".moving"}, int'(bus.moving), mv);
        chk({tag, ".arrive"}, int'(bus.arrive), ar);
        chk({tag, ".door"}, int'(bus.door_open), dr);
        chk({tag, ".fault"}, int'(bus.limit_fault), lf);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.motor     = 1'b0;
        bus.direction = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0; n_chk = 0; n_fail = 0;
        rst = 1'b1; bus.motor = 1'b0; bus.direction = 1'b0;
        tick(2);
        rst = 1'b0;
        status("reset", 0, 0, 0, 0, 0);

        // Single floor up with motor dropped at cycle 5
        bus.motor = 1'b1; bus.direction = 1'b1;          // cycle 0
        tick(1); status("one.c1", 0, 1, 0, 0, 0);
        tick(4); bus.motor = 1'b0;                       // cycle 5
        tick(3); status("one.c8", 0, 1, 0, 0, 0);
        tick(1); status("one.arr", 1, 0, 1, 1, 0);
        tick(1); status("one.door2", 1, 0, 0, 1, 0);
        tick(2); status("one.door4", 1, 0, 0, 1, 0);
        tick(1); status("one.park", 1, 0, 0, 0, 0);

        // Continuous travel from floor 0, then stop at the next floor
        do_reset();
        bus.motor = 1'b1; bus.direction = 1'b1;
        tick(9);  status("run.f1", 1, 1, 1, 0, 0);
        tick(1);  status("run.f1b", 1, 1, 0, 0, 0);
        tick(7);  status("run.f2", 2, 1, 1, 0, 0);
        bus.motor = 1'b0;
        tick(8);  status("run.f3", 3, 0, 1, 1, 0);
        tick(4);  status("run.park3", 3, 0, 0, 0, 0);

        // Arrive at top floor with motor still requesting up
        bus.motor = 1'b1; bus.direction = 1'b1;
        tick(1);  status("top.go", 3, 1, 0, 0, 0);
        tick(8);  status("top.arr", 4, 0, 1, 1, 1);
        tick(4);  status("top.park", 4, 0, 0, 0, 1);
        tick(2);  status("top.hold", 4, 0, 0, 0, 1);
        bus.motor = 1'b0;
        tick(3);  status("top.sticky", 4, 0, 0, 0, 1);

        // Down request at floor 0 while parked
        do_reset();
        status("bot.rst", 0, 0, 0, 0, 0);
        bus.motor = 1'b1; bus.direction = 1'b0;
        tick(1);  status("bot.fault", 0, 0, 0, 0, 1);
        tick(2);  status("bot.hold", 0, 0, 0, 0, 1);

        // Reset in the middle of segment 2->3
        do_reset();
        bus.motor = 1'b1; bus.direction = 1'b1;
        tick(17); status("mid.f2", 2, 1, 1, 0, 0);
        tick(3);
        rst = 1'b1;
        tick(1);  status("mid.rst", 0, 0, 0, 0, 0);
        rst = 1'b0; bus.motor = 1'b0;
        tick(2);  status("mid.idle", 0, 0, 0, 0, 0);

        // Request during DOORS at floor 2 is deferred; then down, reversal at floor 1
        bus.motor = 1'b1; bus.direction = 1'b1;
        tick(9);  status("dr.f1", 1, 1, 1, 0, 0);
        bus.motor = 1'b0;
        tick(8);  status("dr.f2", 2, 0, 1, 1, 0);
        bus.motor = 1'b1; bus.direction = 1'b0;
        tick(3);  status("dr.door4", 2, 0, 0, 1, 0);
        tick(1);  status("dr.park", 2, 0, 0, 0, 0);
        tick(1);  status("dr.go", 2, 1, 0, 0, 0);
        tick(4);
        bus.direction = 1'b1;                            // mid-segment change
        tick(3);  status("dr.c8", 2, 1, 0, 0, 0);
        tick(1);  status("dr.f1down", 1, 1, 1, 0, 0);
        tick(8);  status("rev.f2", 2, 1, 1, 0, 0);
        bus.motor = 1'b0;
        tick(8);  status("rev.f3", 3, 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/car_motion_unit.md
CAR_MOTION_UNIT -- requirements
Module: car_motion_unit

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 5, number of served floors (index 0..NUM_FLOORS-1).
REQ-002 SHALL have parameter TRAVEL_CYC, default 8, clock cycles to move one floor (>=2).
REQ-003 SHALL have parameter DOOR_CYC, default 4, cycles door stays open after a stop (>=1).
REQ-004 SHALL have parameter START_FLOOR, default 0, floor index loaded at reset.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 motor  input  1  1 = controller requests movement, 0 = stop.
REQ-009 direction  input  1  1 = up, 0 = down; meaningful only while motor=1.
REQ-010 floor_cur  output  5  binary index of the car's current/last-passed floor.
REQ-011 moving  output  1  1 while the car is between floors (TRAVEL state).
REQ-012 arrive  output  1  one-cycle pulse on the cycle floor_cur changes.
REQ-013 door_open  output  1  1 while in DOORS state.
REQ-014 limit_fault  output  1  sticky; set on any motion request past floor 0 or NUM_FLOORS-1.

Function
REQ-015 SHALL implement FSM states PARKED, TRAVEL, DOORS; only one active per cycle.
REQ-016 PARKED: door closed, moving=0; if motor=1 and move is legal, next state TRAVEL, segment counter cleared, direction latched.
REQ-017 PARKED, illegal request (up at NUM_FLOORS-1 or down at 0): limit_fault<=1, stay PARKED, floor_cur unchanged.
REQ-018 TRAVEL: counter increments each cycle; width $clog2(TRAVEL_CYC); counter wraps to 0 at segment end.
REQ-019 Segment end (counter==TRAVEL_CYC-1): floor_cur +1 (up) or -1 (down), arrive=1 for that cycle's update only.
REQ-020 Latched direction SHALL NOT change mid-segment; direction input changes take effect only at a segment end.
REQ-021 motor=0 sampled on any TRAVEL cycle SHALL set stop_pending; car always finishes current segment (no stop between floors).
REQ-022 At segment end: stop_pending=1 or motor=0 -> DOORS; else continue TRAVEL with direction sampled that cycle.
REQ-023 Continuing past an end floor at segment end (new floor 0 going down, or NUM_FLOORS-1 going up, with motor=1 in same direction): limit_fault<=1, go DOORS.
REQ-024 Reversal at segment end with motor=1 is legal; SHALL start new segment in the new direction without passing through PARKED.
REQ-025 DOORS: door_open=1 for exactly DOOR_CYC cycles; motor ignored; then PARKED (stop_pending cleared).
REQ-026 motor=1 at DOORS expiry: one PARKED cycle, then TRAVEL (request re-evaluated in PARKED).
REQ-027 floor_cur SHALL never leave 0..NUM_FLOORS-1; upper 5-bit values unreachable.
REQ-028 moving and door_open SHALL never be 1 simultaneously.

Reset
REQ-029 rst=1 at a rising edge: state PARKED, floor_cur=START_FLOOR, counter=0, stop_pending=0, moving=0, arrive=0, door_open=0, limit_fault=0.
REQ-030 Reset mid-TRAVEL or mid-DOORS SHALL abandon the segment/timer immediately, with the same values as REQ-029.
REQ-031 rst has priority over all inputs on the same cycle.

Verification (defaults: NUM_FLOORS=5, TRAVEL_CYC=8, DOOR_CYC=4, START_FLOOR=0)
REQ-032 Reset, motor=1 direction=1 at cycle 0, motor=0 at cycle 5 -> moving=1 from cycle 1; floor_cur=1 with arrive pulse after 8 TRAVEL cycles; door_open=1 for 4 cycles; then PARKED, floor_cur=1.
REQ-033 motor=1 direction=1 held continuously from floor 0 -> floor_cur 1 then 2 at 8-cycle intervals, arrive each time, no door_open between; drop motor -> stop at next floor.
REQ-034 Car parked at floor 4, motor=1 direction=1 -> limit_fault=1, moving=0, floor_cur=4; fault persists after motor=0 until rst.
REQ-035 Travel up with motor held so floor 4 is reached with motor=1 direction=1 -> floor_cur=4, limit_fault=1, door_open=1, no increment beyond 4.
REQ-036 rst pulsed at TRAVEL cycle 3 of segment 2->3 -> next cycle floor_cur=0, moving=0, door_open=0, arrive=0.
REQ-037 motor=1 direction=0 asserted during DOORS at floor 2 -> ignored for remaining door cycles; one PARKED cycle; TRAVEL down; floor_cur=1 after 8 cycles.
